// File: rtl/matrix_mul_seq_if.sv
// Operand/result handshake bundle for matrix_mul_seq.
// acc_in exists only when MATMUL_ACC_EN is defined.
interface matrix_mul_seq_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned ROW    = 3,
    parameter int unsigned COL    = 3,
    parameter int unsigned NUM    = 3
);
    localparam int unsigned OWIDTH = 2 * DWIDTH + $clog2(NUM);

    logic                         in_vld;
    logic                         in_rdy;
    logic                         is_signed;
    logic [DWIDTH*ROW*NUM-1:0]    din_A;
    logic [DWIDTH*COL*NUM-1:0]    din_B;
    logic [OWIDTH*ROW*COL-1:0]    dout_C;
    logic                         out_vld;
    logic                         out_rdy;
    logic                         busy;
`ifdef MATMUL_ACC_EN
    logic                         acc_in;
`endif

    modport master (
        output in_vld, is_signed, din_A, din_B, out_rdy,
        input  in_rdy, dout_C, out_vld, busy
`ifdef MATMUL_ACC_EN
        , output acc_in
`endif
    );

    modport slave (
        input  in_vld, is_signed, din_A, din_B, out_rdy,
        output in_rdy, dout_C, out_vld, busy
`ifdef MATMUL_ACC_EN
        , input acc_in
`endif
    );
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential C = A x B, one inner-dimension step per cycle for all elements.
// Optional MATMUL_ACC_EN adds acc_in to accumulate onto the previous result.
module matrix_mul_seq #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned ROW    = 3,
    parameter int unsigned COL    = 3,
    parameter int unsigned NUM    = 3
) (
    input  logic             clk,
    input  logic             rst,
    matrix_mul_seq_if.slave  bus
);
    localparam int unsigned OWIDTH = 2 * DWIDTH + $clog2(NUM);
    localparam int unsigned PWIDTH = 2 * DWIDTH;
    localparam int unsigned KW     = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned AW     = DWIDTH * ROW * NUM;
    localparam int unsigned BW     = DWIDTH * COL * NUM;
    localparam int unsigned CW     = OWIDTH * ROW * COL;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [CW-1:0] acc_q, acc_d;

    // Product formed at 2*DWIDTH, then extended to OWIDTH per signedness.
    function automatic logic [OWIDTH-1:0] mac_term(input logic [DWIDTH-1:0] a,
                                                   input logic [DWIDTH-1:0] b,
                                                   input logic              sgn);
        logic [PWIDTH-1:0] ax, bx, p;
        logic [OWIDTH-1:0] r;
        if (sgn) begin
            ax = PWIDTH'($signed(a));
            bx = PWIDTH'($signed(b));
        end else begin
            ax = PWIDTH'(a);
            bx = PWIDTH'(b);
        end
        p = ax * bx;
        if (sgn) r = OWIDTH'($signed(p));
        else     r = OWIDTH'(p);
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_vld) begin
                    a_d     = bus.din_A;
                    b_d     = bus.din_B;
                    sgn_d   = bus.is_signed;
                    k_d     = '0;
                    state_d = S_CALC;
`ifdef MATMUL_ACC_EN
                    if (!bus.acc_in) acc_d = '0;
`else
                    acc_d = '0;
`endif
                end
            end
            S_CALC: begin
                for (int unsigned i = 0; i < ROW; i++) begin
                    for (int unsigned j = 0; j < COL; j++) begin
                        acc_d[(i*COL+j)*OWIDTH +: OWIDTH] =
                            acc_q[(i*COL+j)*OWIDTH +: OWIDTH] +
                            mac_term(a_q[(i*NUM+32'(k_q))*DWIDTH +: DWIDTH],
                                     b_q[(j*NUM+32'(k_q))*DWIDTH +: DWIDTH],
                                     sgn_q);
                    end
                end
                if (k_q == KW'(NUM - 1)) state_d = S_DONE;
                else                     k_d     = k_q + KW'(1);
            end
            S_DONE: begin
                if (bus.out_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign bus.in_rdy  = (state_q == S_IDLE);
    assign bus.out_vld = (state_q == S_DONE);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.dout_C  = acc_q;
endmodule
